lsu_dispatch: RTL and testbench

Consumer end of the LSU request bypass FIFO. It takes the head request presented by the bypass, steers it to the load unit or the store unit over valid/ready handshakes, and returns the pop_ld/pop_st pulses that retire the head entry. It tracks in-flight loads and stores against the memory side, enforces load-after-store ordering, and suppresses writeback of loads killed by flush.

---
 rtl/config_pkg.sv | 21 ++
 rtl/lsu_dispatch.sv | 104 ++++++++++
 tb/tb_lsu_dispatch.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/config_pkg.sv
// Shared types for the LSU: functional-unit encoding and the request
// struct carried through the bypass FIFO.
package config_pkg;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        LOAD      = 3'd1,
        STORE     = 3'd2,
        ALU       = 3'd3,
        CTRL_FLOW = 3'd4,
        MULT      = 3'd5,
        CSR       = 3'd6
    } fu_t;

    typedef struct packed {
        logic       valid;
        fu_t        fu;
        logic [3:0] trans_id;
    } lsu_ctrl_t;

endpackage

// File: rtl/lsu_dispatch.sv
// Consumer end of the LSU bypass FIFO: steers the head request to the load or
// store unit, counts in-flight memory ops and suppresses writeback of flushed loads.
module lsu_dispatch #(
    parameter type         lsu_ctrl_t = config_pkg::lsu_ctrl_t,
    parameter int unsigned MAX_LD     = 2,
    parameter int unsigned MAX_ST     = 2,
    parameter bit          ORDERED    = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      flush_i,
    input  lsu_ctrl_t lsu_ctrl_i,
    output logic      pop_ld_o,
    output logic      pop_st_o,
    output lsu_ctrl_t ld_req_o,
    output logic      ld_valid_o,
    input  logic      ld_ready_i,
    output lsu_ctrl_t st_req_o,
    output logic      st_valid_o,
    input  logic      st_ready_i,
    input  logic      ld_resp_valid_i,
    input  logic      st_resp_valid_i,
    output logic      ld_wb_valid_o,
    output logic      idle_o
);

    localparam int LD_W = $clog2(MAX_LD + 1);
    localparam int ST_W = $clog2(MAX_ST + 1);

    logic [LD_W-1:0] ld_cnt, ld_next;
    logic [ST_W-1:0] st_cnt, st_next;
    logic [LD_W-1:0] kill_cnt, kill_next;

    logic is_load, is_store, ld_room, st_room, st_block, kill_hit;

    assign is_load  = lsu_ctrl_i.valid && (lsu_ctrl_i.fu == config_pkg::LOAD);
    assign is_store = lsu_ctrl_i.valid && (lsu_ctrl_i.fu == config_pkg::STORE);

    // Gates use registered counts only, so a freed slot is usable the next cycle.
    assign ld_room  = ld_cnt < LD_W'(MAX_LD);
    assign st_room  = st_cnt < ST_W'(MAX_ST);
    assign st_block = ORDERED && (st_cnt != '0);

    assign ld_valid_o = is_load && ld_room && !st_block && !flush_i;
    assign st_valid_o = is_store && st_room && !flush_i;
    assign pop_ld_o   = ld_valid_o && ld_ready_i;
    assign pop_st_o   = st_valid_o && st_ready_i;

    assign ld_req_o = lsu_ctrl_i;
    assign st_req_o = lsu_ctrl_i;

    assign kill_hit      = ld_resp_valid_i && (kill_cnt != '0);
    assign ld_wb_valid_o = ld_resp_valid_i && (kill_cnt == '0) && !flush_i;
    assign idle_o        = (ld_cnt == '0) && (st_cnt == '0) && (kill_cnt == '0);

    always_comb begin
        ld_next = ld_cnt;
        if (pop_ld_o && !ld_resp_valid_i) begin
            ld_next = ld_cnt + LD_W'(1);
        end else if (!pop_ld_o && ld_resp_valid_i) begin
            ld_next = ld_cnt - LD_W'(1);
        end

        st_next = st_cnt;
        if (pop_st_o && !st_resp_valid_i) begin
            st_next = st_cnt + ST_W'(1);
        end else if (!pop_st_o && st_resp_valid_i) begin
            st_next = st_cnt - ST_W'(1);
        end

        // On flush every load still outstanding after this cycle becomes a kill.
        kill_next = kill_cnt;
        if (flush_i) begin
            kill_next = ld_cnt - LD_W'(ld_resp_valid_i);
        end else if (kill_hit) begin
            kill_next = kill_cnt - LD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_cnt   <= '0;
            st_cnt   <= '0;
            kill_cnt <= '0;
        end else begin
            ld_cnt   <= ld_next;
            st_cnt   <= st_next;
            kill_cnt <= kill_next;
        end
    end

    a_fu_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lsu_ctrl_i.valid |-> (lsu_ctrl_i.fu == config_pkg::LOAD || lsu_ctrl_i.fu == config_pkg::STORE));

    a_ld_resp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ld_resp_valid_i |-> (ld_cnt != '0));

    a_st_resp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        st_resp_valid_i |-> (st_cnt != '0));

    a_pop_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_ld_o && pop_st_o));

endmodule

// File: tb/tb_lsu_dispatch.sv
// Directed bench for lsu_dispatch: inputs change on the falling edge, outputs
// are checked 1ns later, state updates land on the rising edge in between.
module tb_lsu_dispatch;
    import config_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      flush;
    lsu_ctrl_t req;
    logic      pop_ld, pop_st;
    lsu_ctrl_t ld_req, st_req;
    logic      ld_valid, ld_ready;
    logic      st_valid, st_ready;
    logic      ld_resp, st_resp;
    logic      ld_wb, idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dispatch dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .lsu_ctrl_i     (req),
        .pop_ld_o       (pop_ld),
        .pop_st_o       (pop_st),
        .ld_req_o       (ld_req),
        .ld_valid_o     (ld_valid),
        .ld_ready_i     (ld_ready),
        .st_req_o       (st_req),
        .st_valid_o     (st_valid),
        .st_ready_i     (st_ready),
        .ld_resp_valid_i(ld_resp),
        .st_resp_valid_i(st_resp),
        .ld_wb_valid_o  (ld_wb),
        .idle_o         (idle)
    );

    function automatic lsu_ctrl_t mk(input fu_t f, input logic [3:0] id);
        lsu_ctrl_t r;
        r.valid    = 1'b1;
        r.fu       = f;
        r.trans_id = id;
        return r;
    endfunction

    task automatic clear_inputs();
        flush    = 1'b0;
        req      = '0;
        ld_ready = 1'b0;
        st_ready = 1'b0;
        ld_resp  = 1'b0;
        st_resp  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle: got %b want 1", idle); end
        checks++; if (ld_valid !== 1'b0 || st_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got ld=%b st=%b want 0 0", ld_valid, st_valid); end
        checks++; if (pop_ld !== 1'b0 || pop_st !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop: got ld=%b st=%b want 0 0", pop_ld, pop_st); end
        checks++; if (ld_wb !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb: got %b want 0", ld_wb); end
    endtask

    task automatic test_load_dispatch();
        @(negedge clk); clear_inputs(); req = mk(LOAD, 4'd1); ld_ready = 1'b1; #1;
        checks++; if (ld_valid !== 1'b1 || pop_ld !== 1'b1) begin errors++; $display("[TB] FAIL ld_dispatch: got valid=%b pop=%b want 1 1", ld_valid, pop_ld); end
        checks++; if (st_valid !== 1'b0 || pop_st !== 1'b0) begin errors++; $display("[TB] FAIL ld_no_store: got valid=%b pop=%b want 0 0", st_valid, pop_st); end
        checks++; if (ld_req !== mk(LOAD, 4'd1)) begin errors++; $display("[TB] FAIL ld_req_pass: got %h want %h", ld_req, mk(LOAD, 4'd1)); end
        @(negedge clk); clear_inputs(); ld_resp = 1'b1; #1;
        checks++; if (ld_wb !== 1'b1) begin errors++; $display("[TB] FAIL ld_wb: got %b want 1", ld_wb); end
        checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL ld_busy: got idle=%b want 0", idle); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (idle !== 1'b1 || ld_wb !== 1'b0) begin errors++; $display("[TB] FAIL ld_drain: got idle=%b wb=%b want 1 0", idle, ld_wb); end
    endtask

    task automatic test_load_saturation();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); req = mk(LOAD, 4'(2 + i)); ld_ready = 1'b1; #1;
            checks++; if (pop_ld !== 1'b1) begin errors++; $display("[TB] FAIL sat_pop%0d: got %b want 1", i, pop_ld); end
        end
        @(negedge clk); req = mk(LOAD, 4'd4); #1;
        checks++; if (ld_valid !== 1'b0 || pop_ld !== 1'b0) begin errors++; $display("[TB] FAIL sat_hold: got valid=%b pop=%b want 0 0", ld_valid, pop_ld); end
        @(negedge clk); ld_resp = 1'b1; #1;
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_same_cycle: got valid=%b want 0", ld_valid); end
        checks++; if (ld_wb !== 1'b1) begin errors++; $display("[TB] FAIL sat_wb: got %b want 1", ld_wb); end
        @(negedge clk); ld_resp = 1'b0; #1;
        checks++; if (ld_valid !== 1'b1 || pop_ld !== 1'b1) begin errors++; $display("[TB] FAIL sat_resume: got valid=%b pop=%b want 1 1", ld_valid, pop_ld); end
        @(negedge clk); req = mk(LOAD, 4'd5); #1;
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL sat_full_again: got valid=%b want 0", ld_valid); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); ld_resp = 1'b1; #1;
        end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL sat_drain: got idle=%b want 1", idle); end
    endtask

    task automatic test_store_full();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); req = mk(STORE, 4'(6 + i)); st_ready = 1'b1; #1;
            checks++; if (st_valid !== 1'b1 || pop_st !== 1'b1 || pop_ld !== 1'b0) begin errors++; $display("[TB] FAIL st_pop%0d: got valid=%b pop=%b pop_ld=%b want 1 1 0", i, st_valid, pop_st, pop_ld); end
        end
        @(negedge clk); req = mk(STORE, 4'd8); #1;
        checks++; if (st_valid !== 1'b0 || pop_st !== 1'b0) begin errors++; $display("[TB] FAIL st_full: got valid=%b pop=%b want 0 0", st_valid, pop_st); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); st_resp = 1'b1; #1;
        end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL st_drain: got idle=%b want 1", idle); end
    endtask

    task automatic test_ordering();
        @(negedge clk); clear_inputs(); req = mk(STORE, 4'd9); st_ready = 1'b1; #1;
        checks++; if (pop_st !== 1'b1) begin errors++; $display("[TB] FAIL ord_store: got pop=%b want 1", pop_st); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); req = mk(LOAD, 4'd10); ld_ready = 1'b1; #1;
            checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL ord_block%0d: got valid=%b want 0", i, ld_valid); end
        end
        @(negedge clk); st_resp = 1'b1; #1;
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("[TB] FAIL ord_resp_cycle: got valid=%b want 0", ld_valid); end
        @(negedge clk); st_resp = 1'b0; #1;
        checks++; if (ld_valid !== 1'b1 || pop_ld !== 1'b1) begin errors++; $display("[TB] FAIL ord_release: got valid=%b pop=%b want 1 1", ld_valid, pop_ld); end
        @(negedge clk); clear_inputs(); ld_resp = 1'b1; #1;
        checks++; if (ld_wb !== 1'b1) begin errors++; $display("[TB] FAIL ord_wb: got %b want 1", ld_wb); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL ord_drain: got idle=%b want 1", idle); end
    endtask

    task automatic test_flush_inflight();
        @(negedge clk); clear_inputs(); flush = 1'b1; req = mk(LOAD, 4'd11); ld_ready = 1'b1; #1;
        checks++; if (ld_valid !== 1'b0 || pop_ld !== 1'b0) begin errors++; $display("[TB] FAIL fl_no_ld: got valid=%b pop=%b want 0 0", ld_valid, pop_ld); end
        req = mk(STORE, 4'd11); st_ready = 1'b1; #1;
        checks++; if (st_valid !== 1'b0 || pop_st !== 1'b0) begin errors++; $display("[TB] FAIL fl_no_st: got valid=%b pop=%b want 0 0", st_valid, pop_st); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL fl_empty_idle: got idle=%b want 1", idle); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); req = mk(LOAD, 4'(12 + i)); ld_ready = 1'b1; #1;
        end
        @(negedge clk); clear_inputs(); flush = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); ld_resp = 1'b1; #1;
            checks++; if (ld_wb !== 1'b0) begin errors++; $display("[TB] FAIL fl_kill%0d: got wb=%b want 0", i, ld_wb); end
            checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL fl_busy%0d: got idle=%b want 0", i, idle); end
        end
        @(negedge clk); clear_inputs(); req = mk(LOAD, 4'd14); ld_ready = 1'b1; #1;
        checks++; if (idle !== 1'b1 || pop_ld !== 1'b1) begin errors++; $display("[TB] FAIL fl_fresh: got idle=%b pop=%b want 1 1", idle, pop_ld); end
        @(negedge clk); clear_inputs(); ld_resp = 1'b1; #1;
        checks++; if (ld_wb !== 1'b1) begin errors++; $display("[TB] FAIL fl_fresh_wb: got %b want 1", ld_wb); end
        @(negedge clk); clear_inputs(); #1;
    endtask

    task automatic test_flush_coincident();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); req = mk(LOAD, 4'(1 + i)); ld_ready = 1'b1; #1;
        end
        @(negedge clk); clear_inputs(); flush = 1'b1; ld_resp = 1'b1; #1;
        checks++; if (ld_wb !== 1'b0) begin errors++; $display("[TB] FAIL co_flush_wb: got %b want 0", ld_wb); end
        @(negedge clk); clear_inputs(); ld_resp = 1'b1; #1;
        checks++; if (ld_wb !== 1'b0 || idle !== 1'b0) begin errors++; $display("[TB] FAIL co_kill: got wb=%b idle=%b want 0 0", ld_wb, idle); end
        @(negedge clk); clear_inputs(); #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL co_idle: got %b want 1", idle); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); clear_inputs(); req = mk(LOAD, 4'd3); ld_ready = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); clear_inputs(); req = mk(STORE, 4'(4 + i)); st_ready = 1'b1; #1;
        end
        @(negedge clk); clear_inputs(); flush = 1'b1; #1;
        @(negedge clk); clear_inputs(); #1;
        checks++; if (idle !== 1'b0) begin errors++; $display("[TB] FAIL ar_busy: got idle=%b want 0", idle); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("[TB] FAIL ar_idle: got %b want 1", idle); end
        checks++; if (ld_valid !== 1'b0 || st_valid !== 1'b0 || pop_ld !== 1'b0 || pop_st !== 1'b0 || ld_wb !== 1'b0) begin errors++; $display("[TB] FAIL ar_outputs: got %b%b%b%b%b want 00000", ld_valid, st_valid, pop_ld, pop_st, ld_wb); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); clear_inputs(); req = mk(LOAD, 4'd7); ld_ready = 1'b1; #1;
        checks++; if (pop_ld !== 1'b1) begin errors++; $display("[TB] FAIL ar_st_cleared: got pop=%b want 1", pop_ld); end
        @(negedge clk); clear_inputs(); ld_resp = 1'b1; #1;
        checks++; if (ld_wb !== 1'b1) begin errors++; $display("[TB] FAIL ar_kill_cleared: got wb=%b want 1", ld_wb); end
        @(negedge clk); clear_inputs(); #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_load_dispatch();
        test_load_saturation();
        test_store_full();
        test_ordering();
        test_flush_inflight();
        test_flush_coincident();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
